// File: rtl/push_debouncer.sv
// Debounces one active-low push/handshake input: a two-flop synchronizer feeds a
// counting filter that accepts a new level only after 2^N consecutive differing clocks.
module push_debouncer #(
  parameter int N = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic push_in,
  output logic push_level,
  output logic falling_edge,
  output logic rising_edge
);

  localparam logic [N-1:0] CNT_MAX = '1;

  logic         sync1;
  logic         sync2;
  logic         stable;
  logic [N-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!reset) begin
      sync1        <= 1'b1;
      sync2        <= 1'b1;
      stable       <= 1'b1;
      cnt          <= '0;
      falling_edge <= 1'b0;
      rising_edge  <= 1'b0;
    end else begin
      sync1        <= push_in;
      sync2        <= sync1;
      falling_edge <= 1'b0;
      rising_edge  <= 1'b0;
      // Any agreement with the current level restarts the qualification window.
      if (sync2 == stable) begin
        cnt <= '0;
      end else if (cnt == CNT_MAX) begin
        stable       <= sync2;
        cnt          <= '0;
        falling_edge <= ~sync2;
        rising_edge  <= sync2;
      end else begin
        cnt <= cnt + N'(1);
      end
    end
  end

  assign push_level = stable;

endmodule

// File: tb/tb_push_debouncer.sv
// Self-checking bench for push_debouncer: an N=4 and an N=1 instance, per-cycle
// expected outputs queued as stimulus is driven and compared one edge later.
module tb_push_debouncer;

  logic clk;
  logic reset4, push4, level4, fall4, rise4;
  logic reset1, push1, level1, fall1, rise1;

  // {level4, fall4, rise4, level1, fall1, rise1} expected after each edge
  logic [5:0] exp_q[$];

  int n_cmp;
  int n_err;

  logic exp_lvl4;
  logic exp_lvl1;

  push_debouncer #(.N(4)) dut4 (
    .clk          (clk),
    .reset        (reset4),
    .push_in      (push4),
    .push_level   (level4),
    .falling_edge (fall4),
    .rising_edge  (rise4)
  );

  push_debouncer #(.N(1)) dut1 (
    .clk          (clk),
    .reset        (reset1),
    .push_in      (push1),
    .push_level   (level1),
    .falling_edge (fall1),
    .rising_edge  (rise1)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic got, input logic exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
    end
  endtask

  // scoreboard: pop one expectation per edge, sampled 1 time unit after it
  always @(posedge clk) begin
    logic [5:0] e;
    #1;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check("level4", level4, e[5]);
      check("fall4",  fall4,  e[4]);
      check("rise4",  rise4,  e[3]);
      check("level1", level1, e[2]);
      check("fall1",  fall1,  e[1]);
      check("rise1",  rise1,  e[0]);
    end
  end

  // driver tasks
  task automatic drive(input logic p4, input logic r4, input logic p1, input logic r1,
                       input logic [5:0] exp_v);
    @(negedge clk);
    push4  = p4;
    reset4 = r4;
    push1  = p1;
    reset1 = r1;
    exp_q.push_back(exp_v);
  endtask

  // N=4 instance active, N=1 instance held in reset.
  // accept_at is the edge index (first driven edge = 0) where the level flips; -1 = never.
  task automatic hold4(input logic p, input int cycles, input int accept_at);
    for (int i = 0; i < cycles; i++) begin
      logic f;
      logic r;
      f = 1'b0;
      r = 1'b0;
      if (i == accept_at) begin
        exp_lvl4 = p;
        f = ~p;
        r = p;
      end
      drive(p, 1'b1, 1'b1, 1'b0, {exp_lvl4, f, r, 3'b100});
    end
  endtask

  task automatic reset4_for(input logic p, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      exp_lvl4 = 1'b1;
      drive(p, 1'b0, 1'b1, 1'b0, 6'b100_100);
    end
  endtask

  // N=1 instance active, N=4 instance held in reset.
  task automatic hold1(input logic p, input int cycles, input int accept_at);
    for (int i = 0; i < cycles; i++) begin
      logic f;
      logic r;
      f = 1'b0;
      r = 1'b0;
      if (i == accept_at) begin
        exp_lvl1 = p;
        f = ~p;
        r = p;
      end
      drive(1'b1, 1'b0, p, 1'b1, {3'b100, exp_lvl1, f, r});
    end
  endtask

  initial begin
    n_cmp    = 0;
    n_err    = 0;
    exp_lvl4 = 1'b1;
    exp_lvl1 = 1'b1;
    push4    = 1'b0;
    reset4   = 1'b0;
    push1    = 1'b1;
    reset1   = 1'b0;

    // reset held with the input asserted
    reset4_for(1'b0, 3);
    // idle high, then a clean press accepted at edge 17, then held
    hold4(1'b1, 20, -1);
    hold4(1'b0, 118, 17);
    // release
    hold4(1'b1, 30, 17);
    // bounces: low 10 / high 3, five times, never accepted
    for (int k = 0; k < 5; k++) begin
      hold4(1'b0, 10, -1);
      hold4(1'b1, 3, -1);
    end
    hold4(1'b0, 30, 17);
    hold4(1'b1, 20, 17);
    // reset in the middle of a count discards progress
    hold4(1'b0, 10, -1);
    reset4_for(1'b0, 1);
    hold4(1'b0, 20, 17);
    // reset while the level is low returns it high with no strobe
    reset4_for(1'b0, 2);
    hold4(1'b1, 5, -1);

    // N=1: idle, single-clock glitch rejected, held low accepted at edge 3, release
    hold1(1'b1, 4, -1);
    hold1(1'b0, 1, -1);
    hold1(1'b1, 6, -1);
    hold1(1'b0, 8, 3);
    hold1(1'b1, 8, 3);

    // drain the scoreboard with a bounded wait
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
    @(posedge clk);
    #2;
    check("queue_drained", exp_q.size() == 0, 1'b1);

    // final report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
